// File: rtl/neurram_pkg.sv
// Shared Neurram definitions: FSM state encodings, trigger hold time and host byte layout.
// Also used by neuron_multi_level_output.
package neurram_pkg;

  localparam int MAG_W     = 7;
  localparam int TRIG_HOLD = 4;
  localparam int BYTE_W    = 8;
  localparam int SIGN_BIT  = 7;
  localparam int HOLD_W    = $clog2(TRIG_HOLD + 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BUILD,
    ST_SPI_TRIG,
    ST_SPI_WAIT,
    ST_PULSE_TRIG,
    ST_PULSE_WAIT,
    ST_NEXT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mli_step_encoder.sv
// Combinational step encoder: turns per-row magnitude/sign into the interleaved
// pos/neg SPI row vector for step s, and flags whether step s+1 would drive anything.
module mli_step_encoder
  import neurram_pkg::*;
#(
  parameter int spi_length = 256
) (
  input  logic [spi_length-1:0][MAG_W-1:0] i_mag,
  input  logic [spi_length-1:0]            i_sign,
  input  logic [MAG_W-1:0]                 i_step,
  output logic [2*spi_length-1:0]          o_spi_data,
  output logic                             o_any_active_next
);

  logic [spi_length-1:0] w_act;
  logic [spi_length-1:0] w_act_next;
  logic [MAG_W:0]        w_step_p1;

  // One extra bit so s+1 can never wrap below a large magnitude.
  assign w_step_p1 = {1'b0, i_step} + (MAG_W + 1)'(1);

  genvar gi;
  generate
    for (gi = 0; gi < spi_length; gi++) begin : g_row
      assign w_act[gi]            = i_mag[gi] > i_step;
      assign w_act_next[gi]       = {1'b0, i_mag[gi]} > w_step_p1;
      assign o_spi_data[2*gi]     = w_act[gi] & ~i_sign[gi];
      assign o_spi_data[2*gi + 1] = w_act[gi] & i_sign[gi];
    end
  endgenerate

  assign o_any_active_next = |w_act_next;

endmodule

// File: rtl/neuron_multi_level_input.sv
// Host-to-array multi-level input transmitter: unpacks {sign,mag} bytes from the host FIFO,
// then per step writes a binary row vector over SPI and fires one input pulse.
module neuron_multi_level_input
  import neurram_pkg::*;
#(
  parameter int spi_length = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    input_trigger,
  input  logic [MAG_W-1:0]        num_steps,
  output logic                    idle,
  output logic                    done,
  input  logic [31:0]             in_fifo_dout,
  input  logic                    in_fifo_valid,
  output logic                    in_fifo_rd_en,
  output logic [2*spi_length-1:0] spi_data,
  output logic                    spi_write_trigger,
  input  logic                    spi_idle,
  output logic                    pulse_trigger,
  input  logic                    pulse_idle,
  output logic [MAG_W-1:0]        steps_issued
);

  // Each FIFO word carries four rows, so the word counter is the row index minus two bits.
  localparam int ROW_W  = $clog2(spi_length);
  localparam int WORD_W = ROW_W - 2;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(spi_length / 4 - 1);

  state_t                          r_state;
  state_t                          w_state_next;
  logic [WORD_W-1:0]               r_word_cnt;
  logic [MAG_W-1:0]                r_step;
  logic [MAG_W-1:0]                r_num_steps;
  logic [MAG_W-1:0]                r_steps_issued;
  logic [HOLD_W-1:0]               r_hold_cnt;
  logic [spi_length-1:0][MAG_W-1:0] r_mag;
  logic [spi_length-1:0]           r_sign;
  logic [2*spi_length-1:0]         r_spi_data;
  logic [2*spi_length-1:0]         w_spi_data;
  logic                            w_any_active_next;
  logic                            w_hold_last;
  logic [MAG_W-1:0]                w_step_plus1;

  mli_step_encoder #(
    .spi_length(spi_length)
  ) u_step_encoder (
    .i_mag            (r_mag),
    .i_sign           (r_sign),
    .i_step           (r_step),
    .o_spi_data       (w_spi_data),
    .o_any_active_next(w_any_active_next)
  );

  assign w_hold_last  = (r_hold_cnt == HOLD_W'(TRIG_HOLD - 1));
  assign w_step_plus1 = r_step + MAG_W'(1);

  always_comb begin
    w_state_next      = r_state;
    idle              = 1'b0;
    done              = 1'b0;
    in_fifo_rd_en     = 1'b0;
    spi_write_trigger = 1'b0;
    pulse_trigger     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        idle = ~rst;
        if (input_trigger) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        in_fifo_rd_en = 1'b1;
        if (in_fifo_valid && (r_word_cnt == LAST_WORD))
          w_state_next = (r_num_steps == '0) ? ST_DONE : ST_BUILD;
      end
      ST_BUILD: w_state_next = ST_SPI_TRIG;
      ST_SPI_TRIG: begin
        spi_write_trigger = 1'b1;
        if (w_hold_last) w_state_next = ST_SPI_WAIT;
      end
      ST_SPI_WAIT: if (spi_idle) w_state_next = ST_PULSE_TRIG;
      ST_PULSE_TRIG: begin
        pulse_trigger = 1'b1;
        if (w_hold_last) w_state_next = ST_PULSE_WAIT;
      end
      ST_PULSE_WAIT: if (pulse_idle) w_state_next = ST_NEXT;
      // Stop early once the next row vector would be all zero.
      ST_NEXT: begin
        if ((w_step_plus1 == r_num_steps) || !w_any_active_next) w_state_next = ST_DONE;
        else                                                     w_state_next = ST_BUILD;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_word_cnt     <= '0;
      r_step         <= '0;
      r_num_steps    <= '0;
      r_steps_issued <= '0;
      r_hold_cnt     <= '0;
      r_mag          <= '0;
      r_sign         <= '0;
      r_spi_data     <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (input_trigger) begin
            r_num_steps    <= num_steps;
            r_word_cnt     <= '0;
            r_step         <= '0;
            r_steps_issued <= '0;
          end
        end
        ST_LOAD: begin
          if (in_fifo_valid) begin
            r_word_cnt <= r_word_cnt + WORD_W'(1);
            for (int j = 0; j < 4; j++) begin
              r_mag[{r_word_cnt, 2'(j)}]  <= in_fifo_dout[BYTE_W*j +: MAG_W];
              r_sign[{r_word_cnt, 2'(j)}] <= in_fifo_dout[BYTE_W*j + SIGN_BIT];
            end
          end
        end
        ST_BUILD: r_spi_data <= w_spi_data;
        ST_SPI_TRIG, ST_PULSE_TRIG:
          r_hold_cnt <= w_hold_last ? '0 : r_hold_cnt + HOLD_W'(1);
        ST_PULSE_WAIT: if (pulse_idle) r_steps_issued <= r_steps_issued + MAG_W'(1);
        ST_NEXT: r_step <= w_step_plus1;
        default: ;
      endcase
      if (w_state_next == ST_DONE) r_spi_data <= '0;
    end
  end

  assign spi_data     = r_spi_data;
  assign steps_issued = r_steps_issued;

endmodule

// File: tb/tb_neuron_multi_level_input.sv
// Directed bench for neuron_multi_level_input with an 8-row array, a model host FIFO
// and idle/finished handshakes driven from the bench.
module tb_neuron_multi_level_input;

  localparam int SPI_LEN = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   input_trigger = 1'b0;
  logic [6:0]             num_steps = '0;
  logic                   idle;
  logic                   done;
  logic [31:0]            in_fifo_dout = '0;
  logic                   in_fifo_valid = 1'b0;
  logic                   in_fifo_rd_en;
  logic [2*SPI_LEN-1:0]   spi_data;
  logic                   spi_write_trigger;
  logic                   spi_idle = 1'b1;
  logic                   pulse_trigger;
  logic                   pulse_idle = 1'b1;
  logic [6:0]             steps_issued;

  int total = 0;
  int bad   = 0;

  logic [15:0] spi_log[$];
  logic [31:0] fifo_q[$];
  int  pulse_cnt   = 0;
  int  done_cnt    = 0;
  int  wt_cycles   = 0;
  int  words_taken = 0;
  bit  gap_mode    = 1'b0;

  always #5 clk = ~clk;

  neuron_multi_level_input #(
    .spi_length(SPI_LEN)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .input_trigger    (input_trigger),
    .num_steps        (num_steps),
    .idle             (idle),
    .done             (done),
    .in_fifo_dout     (in_fifo_dout),
    .in_fifo_valid    (in_fifo_valid),
    .in_fifo_rd_en    (in_fifo_rd_en),
    .spi_data         (spi_data),
    .spi_write_trigger(spi_write_trigger),
    .spi_idle         (spi_idle),
    .pulse_trigger    (pulse_trigger),
    .pulse_idle       (pulse_idle),
    .steps_issued     (steps_issued)
  );

  // Host FIFO model: pops on a sampled rd_en&valid, optionally offers data 1 cycle in 3.
  initial begin
    bit take;
    int cyc = 0;
    forever begin
      @(negedge clk);
      take = in_fifo_rd_en && in_fifo_valid;
      @(posedge clk);
      #1;
      if (take) begin
        void'(fifo_q.pop_front());
        words_taken++;
      end
      cyc++;
      in_fifo_valid = (fifo_q.size() > 0) && (!gap_mode || (cyc % 3 == 0));
      in_fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
    end
  end

  // Output monitor, sampled on the falling edge.
  initial begin
    logic prev_wt = 1'b0;
    logic prev_pt = 1'b0;
    forever begin
      @(negedge clk);
      if (spi_write_trigger && !prev_wt) spi_log.push_back(spi_data);
      if (pulse_trigger && !prev_pt) pulse_cnt++;
      if (spi_write_trigger) wt_cycles++;
      if (done) done_cnt++;
      prev_wt = spi_write_trigger;
      prev_pt = pulse_trigger;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < spi_log.size()) return {16'h0, spi_log[i]};
    return 32'hBAD0_0000;
  endfunction

  task automatic load_words(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                            input int n);
    fifo_q.delete();
    fifo_q.push_back(w0);
    fifo_q.push_back(w1);
    if (n > 2) fifo_q.push_back(w2);
  endtask

  task automatic launch(input int n);
    @(negedge clk);
    num_steps     = 7'(n);
    input_trigger = 1'b1;
    @(negedge clk);
    input_trigger = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      tick();
      k++;
    end
    repeat (3) tick();
    check_eq({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0, l0, p0, t0, w0, k;
    logic [15:0] hold_val;
    int unstable, early_pulse;

    // Reset state
    tick();
    tick();
    check_eq("rst_ctrl", {27'h0, idle, done, in_fifo_rd_en, spi_write_trigger, pulse_trigger}, 32'h0);
    check_eq("rst_spi_data", {16'h0, spi_data}, 32'h0);
    check_eq("rst_steps", {25'h0, steps_issued}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_eq("idle_after_rst", {31'h0, idle}, 32'h1);

    // 1: mag {0,1,2,3,5,0,1,2}, all positive, 3 steps, one surplus word
    d0 = done_cnt; l0 = spi_log.size(); p0 = pulse_cnt; t0 = wt_cycles; w0 = words_taken;
    load_words(32'h0302_0100, 32'h0201_0005, 32'h0000_00FF, 3);
    launch(3);
    wait_done("t1", d0, 300);
    check_eq("t1_writes", 32'(spi_log.size() - l0), 32'd3);
    check_eq("t1_step0", log_at(l0), 32'h5154);
    check_eq("t1_step1", log_at(l0 + 1), 32'h4150);
    check_eq("t1_step2", log_at(l0 + 2), 32'h0140);
    check_eq("t1_pulses", 32'(pulse_cnt - p0), 32'd3);
    check_eq("t1_trig_hold", 32'(wt_cycles - t0), 32'd12);
    check_eq("t1_steps_issued", {25'h0, steps_issued}, 32'd3);
    check_eq("t1_words_taken", 32'(words_taken - w0), 32'd2);
    check_eq("t1_surplus_left", 32'(fifo_q.size()), 32'd1);
    check_eq("t1_spi_cleared", {16'h0, spi_data}, 32'h0);
    check_eq("t1_idle", {31'h0, idle}, 32'h1);
    $display("run t1: writes=%0d pulses=%0d steps=%0d", spi_log.size() - l0, pulse_cnt - p0, steps_issued);

    // 2: row 2 negative (byte 0x82), rest as in run 1
    d0 = done_cnt; l0 = spi_log.size(); p0 = pulse_cnt;
    load_words(32'h0382_0100, 32'h0201_0005, 32'h0, 2);
    launch(3);
    wait_done("t2", d0, 300);
    check_eq("t2_writes", 32'(spi_log.size() - l0), 32'd3);
    check_eq("t2_step0", log_at(l0), 32'h5164);
    check_eq("t2_step1", log_at(l0 + 1), 32'h4160);
    check_eq("t2_step2", log_at(l0 + 2), 32'h0140);
    check_eq("t2_pulses", 32'(pulse_cnt - p0), 32'd3);
    $display("run t2: writes=%0d pulses=%0d steps=%0d", spi_log.size() - l0, pulse_cnt - p0, steps_issued);

    // 3: max mag 2 with num_steps=100 exits early after 2 steps
    d0 = done_cnt; l0 = spi_log.size(); p0 = pulse_cnt;
    load_words(32'h0200_0102, 32'h0200_0001, 32'h0, 2);
    launch(100);
    wait_done("t3", d0, 300);
    check_eq("t3_writes", 32'(spi_log.size() - l0), 32'd2);
    check_eq("t3_step0", log_at(l0), 32'h4145);
    check_eq("t3_step1", log_at(l0 + 1), 32'h4041);
    check_eq("t3_pulses", 32'(pulse_cnt - p0), 32'd2);
    check_eq("t3_steps_issued", {25'h0, steps_issued}, 32'd2);
    $display("run t3: writes=%0d pulses=%0d steps=%0d", spi_log.size() - l0, pulse_cnt - p0, steps_issued);

    // 4: num_steps=0 loads the array then finishes without driving it
    d0 = done_cnt; l0 = spi_log.size(); p0 = pulse_cnt; w0 = words_taken;
    load_words(32'h0302_0100, 32'h0201_0005, 32'h1234_5678, 3);
    launch(0);
    wait_done("t4", d0, 100);
    check_eq("t4_writes", 32'(spi_log.size() - l0), 32'd0);
    check_eq("t4_pulses", 32'(pulse_cnt - p0), 32'd0);
    check_eq("t4_words_taken", 32'(words_taken - w0), 32'd2);
    check_eq("t4_surplus_left", 32'(fifo_q.size()), 32'd1);
    check_eq("t4_steps_issued", {25'h0, steps_issued}, 32'd0);
    $display("run t4: writes=%0d pulses=%0d words=%0d", spi_log.size() - l0, pulse_cnt - p0, words_taken - w0);

    // 5: gapped FIFO, SPI writer busy for 20 cycles after the first write
    d0 = done_cnt; l0 = spi_log.size(); p0 = pulse_cnt; w0 = words_taken;
    gap_mode = 1'b1;
    spi_idle = 1'b0;
    load_words(32'h0302_0100, 32'h0201_0005, 32'h0, 2);
    launch(2);
    k = 0;
    while (spi_log.size() == l0 && k < 200) begin
      tick();
      k++;
    end
    check_eq("t5_first_write_seen", 32'(spi_log.size() - l0), 32'd1);
    hold_val = spi_data;
    unstable = 0;
    early_pulse = 0;
    repeat (20) begin
      tick();
      if (spi_data !== hold_val) unstable++;
      if (pulse_trigger) early_pulse++;
    end
    check_eq("t5_spi_stable", 32'(unstable), 32'd0);
    check_eq("t5_held_in_wait", 32'(early_pulse), 32'd0);
    spi_idle = 1'b1;
    wait_done("t5", d0, 300);
    gap_mode = 1'b0;
    check_eq("t5_writes", 32'(spi_log.size() - l0), 32'd2);
    check_eq("t5_step0", log_at(l0), 32'h5154);
    check_eq("t5_step1", log_at(l0 + 1), 32'h4150);
    check_eq("t5_words_taken", 32'(words_taken - w0), 32'd2);
    check_eq("t5_steps_issued", {25'h0, steps_issued}, 32'd2);
    $display("run t5: writes=%0d pulses=%0d steps=%0d", spi_log.size() - l0, pulse_cnt - p0, steps_issued);

    // 6: mid-run trigger ignored, then reset while waiting for the pulse generator
    d0 = done_cnt; l0 = spi_log.size(); p0 = pulse_cnt;
    pulse_idle = 1'b0;
    load_words(32'h0302_0100, 32'h0201_0005, 32'h0, 2);
    launch(3);
    k = 0;
    while (pulse_cnt == p0 && k < 200) begin
      tick();
      k++;
    end
    check_eq("t6_pulse_seen", 32'(pulse_cnt - p0), 32'd1);
    repeat (6) tick();
    @(negedge clk);
    input_trigger = 1'b1;
    @(negedge clk);
    input_trigger = 1'b0;
    tick();
    check_eq("t6_trig_ignored_rd", {31'h0, in_fifo_rd_en}, 32'h0);
    check_eq("t6_trig_ignored_idle", {31'h0, idle}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_eq("t6_rst_ctrl", {27'h0, idle, done, in_fifo_rd_en, spi_write_trigger, pulse_trigger}, 32'h0);
    check_eq("t6_rst_spi_data", {16'h0, spi_data}, 32'h0);
    check_eq("t6_rst_steps", {25'h0, steps_issued}, 32'h0);
    pulse_idle = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) tick();
    check_eq("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("t6_idle", {31'h0, idle}, 32'h1);
    check_eq("t6_writes", 32'(spi_log.size() - l0), 32'd1);
    check_eq("t6_pulses", 32'(pulse_cnt - p0), 32'd1);
    $display("run t6: writes=%0d pulses=%0d done=%0d", spi_log.size() - l0, pulse_cnt - p0, done_cnt - d0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
